// File: rtl/alu_pkg.sv
// Shared ALU result-buffer types and constants.
// Optional statistics are enabled by the ALU_STATS_EN macro in alu_result_buffer.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  localparam int ALU_ENTRY_W = 9;

  typedef struct packed {
    logic [3:0] result;
    logic       cout;
    logic       zero;
    logic [2:0] op;
  } alu_entry_t;

  // Opcodes 5..7 have no defined ALU operation.
  function automatic logic is_reserved(input logic [2:0] op);
    return op > OP_XOR;
  endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// Producer/consumer handshake bundle for alu_result_buffer.
// Both sides use valid/ready: a beat transfers on a rising edge where valid && ready.
interface alu_result_buffer_if;

  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_result;
  logic       in_cout;
  logic       in_zero;
  logic [2:0] in_op;

  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_cout;
  logic       out_zero;
  logic [2:0] out_op;

  modport slave (
    input  in_valid, in_result, in_cout, in_zero, in_op, out_ready,
    output in_ready, out_valid, out_result, out_cout, out_zero, out_op
  );

  modport master (
    output in_valid, in_result, in_cout, in_zero, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_cout, out_zero, out_op
  );

endinterface

// File: rtl/alu_res_mem.sv
// Entry storage for the result buffer: one write port, asynchronous read.
// Contents are not reset; validity is tracked by the buffer's level.
module alu_res_mem
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [ALU_ENTRY_W-1:0]   wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [ALU_ENTRY_W-1:0]   rdata_o
);

  logic [ALU_ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_result_buffer.sv
// FIFO of ALU results with sticky reserved-opcode flag.
// Define ALU_STATS_EN to add saturating carry/zero push counters.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  alu_result_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   rsv_seen
`ifdef ALU_STATS_EN
  ,
  output logic [7:0]             carry_cnt,
  output logic [7:0]             zero_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          rsv_q, rsv_d;
  logic          push, pop;

  alu_entry_t             wr_entry, rd_entry;
  logic [ALU_ENTRY_W-1:0] rd_data;

  assign bus.in_ready  = (level_q != FULL_LVL);
  assign bus.out_valid = (level_q != '0);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  assign wr_entry = {bus.in_result, bus.in_cout, bus.in_zero, bus.in_op};

  // DEPTH is a power of two, so pointers wrap naturally at AW bits.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rsv_d    = rsv_q | (push && is_reserved(bus.in_op));
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rsv_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rsv_q    <= rsv_d;
    end
  end

  alu_res_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (push && !rst),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // Head fields read zero when empty so stale storage never leaks out.
  assign rd_entry       = alu_entry_t'(rd_data);
  assign bus.out_result = bus.out_valid ? rd_entry.result : 4'h0;
  assign bus.out_cout   = bus.out_valid ? rd_entry.cout   : 1'b0;
  assign bus.out_zero   = bus.out_valid ? rd_entry.zero   : 1'b0;
  assign bus.out_op     = bus.out_valid ? rd_entry.op     : 3'h0;

  assign level    = level_q;
  assign rsv_seen = rsv_q;

`ifdef ALU_STATS_EN
  logic [7:0] carry_q, carry_d;
  logic [7:0] zero_q, zero_d;

  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    if (push && bus.in_cout && (carry_q != 8'hFF)) carry_d = carry_q + 8'd1;
    if (push && bus.in_zero && (zero_q  != 8'hFF)) zero_d  = zero_q  + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 8'd0;
      zero_q  <= 8'd0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign carry_cnt = carry_q;
  assign zero_cnt  = zero_q;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer (DEPTH=4); stats checks run when ALU_STATS_EN is defined.
module tb_alu_result_buffer;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] level;
  logic       rsv_seen;
`ifdef ALU_STATS_EN
  logic [7:0] carry_cnt, zero_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;

  alu_result_buffer_if bus();

  alu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .level    (level),
    .rsv_seen (rsv_seen)
`ifdef ALU_STATS_EN
    ,
    .carry_cnt(carry_cnt),
    .zero_cnt (zero_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: handshakes observed at negedge; pushes enqueue, pops compare head.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_empty: out_valid=%b required 0", bus.out_valid);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({bus.out_result, bus.out_cout, bus.out_zero, bus.out_op} !== mon_exp) begin
            n_fail++;
            $display("FAIL head_order: got %h required %h",
                     {bus.out_result, bus.out_cout, bus.out_zero, bus.out_op}, mon_exp);
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back({bus.in_result, bus.in_cout, bus.in_zero, bus.in_op});
    end
  end

  task automatic drive(input logic v, input logic [3:0] res, input logic c,
                       input logic z, input logic [2:0] op, input logic r);
    bus.in_valid  = v;
    bus.in_result = res;
    bus.in_cout   = c;
    bus.in_zero   = z;
    bus.in_op     = op;
    bus.out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 4'h0, 0, 0, 3'd0, 0);
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    drive(0, 4'h0, 0, 0, 3'd0, 1);
    repeat (DEPTH + 1) step();
    drive(0, 4'h0, 0, 0, 3'd0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d required 0", level); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    n_cmp++; if (rsv_seen !== 1'b0) begin n_fail++; $display("FAIL reset_rsv: got %b required 0", rsv_seen); end
    n_cmp++;
    if ({bus.out_result, bus.out_cout, bus.out_zero, bus.out_op} !== 9'h0) begin
      n_fail++; $display("FAIL reset_head: got %h required 000",
                         {bus.out_result, bus.out_cout, bus.out_zero, bus.out_op});
    end
  endtask

  task automatic test_first_word();
    drive(1, 4'h3, 0, 0, OP_ADD, 0);
    step();
    drive(0, 4'h0, 0, 0, 3'd0, 0);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b required 1", bus.out_valid); end
    n_cmp++; if (bus.out_result !== 4'h3) begin n_fail++; $display("FAIL first_result: got %h required 3", bus.out_result); end
    n_cmp++; if (level !== 3'd1) begin n_fail++; $display("FAIL first_level: got %0d required 1", level); end
    drain();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++)
      begin
        drive(1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), 0);
        step();
      end
    n_cmp++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d required 4", level); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b required 0", bus.in_ready); end
    drive(1, 4'hF, 1, 1, OP_XOR, 0);
    step();
    step();
    n_cmp++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_hold_level: got %0d required 4", level); end
    drain();
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL drain_level: got %0d required 0", level); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b required 0", bus.out_valid); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drain_count: %0d entries left, required 0", exp_q.size()); end
  endtask

  task automatic test_simul();
    drive(1, 4'hA, 1, 0, OP_SUB, 0); step();
    drive(1, 4'h5, 0, 1, OP_AND, 0); step();
    drive(1, 4'hC, 1, 1, OP_OR, 1);  step();
    drive(0, 4'h0, 0, 0, 3'd0, 0);
    n_cmp++; if (level !== 3'd2) begin n_fail++; $display("FAIL simul_level: got %0d required 2", level); end
    n_cmp++;
    if ({bus.out_result, bus.out_cout, bus.out_zero, bus.out_op} !== {4'h5, 1'b0, 1'b1, OP_AND}) begin
      n_fail++; $display("FAIL simul_head: got %h required %h",
                         {bus.out_result, bus.out_cout, bus.out_zero, bus.out_op}, {4'h5, 1'b0, 1'b1, OP_AND});
    end
    drain();
  endtask

  task automatic test_rsv();
    drive(1, 4'h1, 0, 0, OP_XOR, 0); step();
    n_cmp++; if (rsv_seen !== 1'b0) begin n_fail++; $display("FAIL rsv_op4: got %b required 0", rsv_seen); end
    drive(1, 4'h2, 0, 0, 3'b110, 0); step();
    n_cmp++; if (rsv_seen !== 1'b1) begin n_fail++; $display("FAIL rsv_set: got %b required 1", rsv_seen); end
    drain();
    n_cmp++; if (rsv_seen !== 1'b1) begin n_fail++; $display("FAIL rsv_sticky: got %b required 1", rsv_seen); end
    do_reset();
    n_cmp++; if (rsv_seen !== 1'b0) begin n_fail++; $display("FAIL rsv_reset: got %b required 0", rsv_seen); end
    drive(1, 4'h0, 0, 1, 3'b101, 1); step();
    n_cmp++; if (rsv_seen !== 1'b1) begin n_fail++; $display("FAIL rsv_op5: got %b required 1", rsv_seen); end
    drain();
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic       pend_v = 1'b0;
    logic [8:0] pend_d = '0;
    logic       acc;
    for (int i = 0; i < 80; i++) begin
      if (!pend_v) begin
        pend_v = 1'($urandom_range(0, 1));
        pend_d = 9'($urandom_range(0, 511));
      end
      drive(pend_v, pend_d[8:5], pend_d[4], pend_d[3], pend_d[2:0], 1'($urandom_range(0, 1)));
      acc = pend_v && bus.in_ready;
      step();
      if (acc) pend_v = 1'b0;
      n_cmp++;
      if (level !== 3'(exp_q.size())) begin
        n_fail++; $display("FAIL b2b_level: cycle %0d got %0d required %0d", i, level, exp_q.size());
      end
    end
    drain();
    do_reset();
  endtask

`ifdef ALU_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1, 4'h7, 1, 0, OP_ADD, 1); step(); end
    n_cmp++; if (carry_cnt !== 8'd5) begin n_fail++; $display("FAIL stats_carry5: got %0d required 5", carry_cnt); end
    n_cmp++; if (zero_cnt !== 8'd0) begin n_fail++; $display("FAIL stats_zero0: got %0d required 0", zero_cnt); end
    for (int i = 0; i < 300; i++) begin
      drive(1, 4'($urandom_range(0, 15)), 1, 1, 3'($urandom_range(0, 4)), 1);
      step();
    end
    drain();
    n_cmp++; if (carry_cnt !== 8'hFF) begin n_fail++; $display("FAIL stats_carry_sat: got %h required ff", carry_cnt); end
    n_cmp++; if (zero_cnt !== 8'hFF) begin n_fail++; $display("FAIL stats_zero_sat: got %h required ff", zero_cnt); end
    do_reset();
    n_cmp++; if (carry_cnt !== 8'h00) begin n_fail++; $display("FAIL stats_reset: got %h required 00", carry_cnt); end
  endtask
`endif

  task automatic test_reset_midstream();
    drive(1, 4'h9, 1, 0, OP_ADD, 0); step();
    drive(1, 4'h8, 0, 0, OP_SUB, 0); step();
    drive(1, 4'h6, 0, 1, OP_OR, 0);  step();
    n_cmp++; if (level !== 3'd3) begin n_fail++; $display("FAIL mid_level3: got %0d required 3", level); end
    rst = 1'b1;
    drive(1, 4'hE, 1, 1, OP_XOR, 0);
    step();
    rst = 1'b0;
    drive(0, 4'h0, 0, 0, 3'd0, 0);
    n_cmp++; if (level !== 3'd0) begin n_fail++; $display("FAIL mid_level0: got %0d required 0", level); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b required 0", bus.out_valid); end
    n_cmp++;
    if ({bus.out_result, bus.out_cout, bus.out_zero, bus.out_op} !== 9'h0) begin
      n_fail++; $display("FAIL mid_head: got %h required 000",
                         {bus.out_result, bus.out_cout, bus.out_zero, bus.out_op});
    end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b required 1", bus.in_ready); end
  endtask

  initial begin
    drive(0, 4'h0, 0, 0, 3'd0, 0);
    test_reset();
    test_first_word();
    test_fill_drain();
    test_simul();
    test_rsv();
    test_back_to_back();
`ifdef ALU_STATS_EN
    test_stats();
`endif
    test_reset_midstream();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter: DEPTH, 4, FIFO entries; legal values 2, 4, 8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  producer presents an ALU result this cycle.
REQ-005 in_ready  output  1  buffer can accept an entry this cycle.
REQ-006 in_result  input  4  ALU result nibble.
REQ-007 in_cout  input  1  ALU carry/borrow out.
REQ-008 in_zero  input  1  ALU zero flag.
REQ-009 in_op  input  3  opcode that produced the result.
REQ-010 out_valid  output  1  head entry available.
REQ-011 out_ready  input  1  consumer accepts head entry this cycle.
REQ-012 out_result / out_cout / out_zero / out_op  output  4/1/1/3  head entry fields.
REQ-013 level  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 rsv_seen  output  1  sticky: a reserved opcode (5-7) was accepted.
REQ-015 carry_cnt, zero_cnt  output  8 each  statistics (present only with ALU_STATS_EN).

Function
REQ-016 The push condition SHALL be in_valid && in_ready; the pop condition SHALL be out_valid && out_ready.
REQ-017 in_ready SHALL equal (level != DEPTH); in_ready SHALL have no combinational dependence on out_ready.
REQ-018 out_valid SHALL equal (level != 0); the head fields SHALL be driven from storage, with zero on all head fields when level == 0.
REQ-019 A pushed entry SHALL appear on the head outputs one cycle after the push, when the buffer was empty (first-word latency = 1).
REQ-020 Entries SHALL leave in push order; the write and read pointers SHALL wrap modulo DEPTH.
REQ-021 A simultaneous push and pop SHALL leave level unchanged; when the buffer is full, this case cannot arise because in_ready = 0.
REQ-022 A pop while empty and a push while full SHALL be impossible by construction, and pointers SHALL not move in either case.
REQ-023 A held in_valid while in_ready = 0 SHALL not be captured, and the producer SHALL keep its data stable until it is accepted.
REQ-024 rsv_seen SHALL set on a push with in_op >= 3'b101 and SHALL stay set until reset.
REQ-025 The entry fields SHALL be stored unmodified: the buffer does not recompute zero or cout.

Reset
REQ-026 On rst = 1 at a clock edge, the following SHALL clear to 0: pointers, level, rsv_seen, and the statistics counters; therefore out_valid = 0 and in_ready = 1 on the next cycle.
REQ-027 Reset asserted mid-stream SHALL discard all stored entries, and a push in the same cycle as reset SHALL be ignored.
REQ-028 Storage array contents SHALL not require reset.

Configuration
REQ-029 Macro ALU_STATS_EN: when defined, carry_cnt SHALL increment on each push with in_cout = 1, and zero_cnt SHALL increment on each push with in_zero = 1.
REQ-030 Both counters SHALL saturate at 8'hFF.
REQ-031 When ALU_STATS_EN is undefined, carry_cnt and zero_cnt SHALL be absent from the port list and no counter logic SHALL be synthesized.

Structure
REQ-032 Shared package alu_pkg SHALL hold the opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, the constant ALU_ENTRY_W=9, and typedef alu_entry_t {result[3:0], cout, zero, op[2:0]}.
REQ-033 Storage SHALL be the sub-module alu_res_mem (DEPTH x ALU_ENTRY_W, 1 write port, asynchronous read); the control and flags SHALL live in alu_result_buffer.

Verification
REQ-034 Reset, then push {result=4'h3, cout=0, zero=0, op=0} -> next cycle out_valid=1, out_result=4'h3, level=1.
REQ-035 Push 4 entries with out_ready=0 (DEPTH=4) -> level=4, in_ready=0; a fifth in_valid is not stored; then drain -> 4 entries out in order and level=0.
REQ-036 At level=2, push and pop in the same cycle -> level stays 2, and the head advances to the second entry.
REQ-037 Push op=3'b110 -> rsv_seen=1 and stays 1 after drain; rst -> rsv_seen=0.
REQ-038 ALU_STATS_EN defined: 300 pushes with in_cout=1 and in_zero=1 -> carry_cnt=zero_cnt=8'hFF.
REQ-039 At level=3, assert rst together with in_valid -> next cycle level=0, out_valid=0, head fields all zero.
